// File: rtl/i2s_pkg.sv
// i2s_pkg: channel-select encodings, the stereo sample type and a width helper
// shared by the I2S transmitter and its sample FIFO.
package i2s_pkg;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Widest supported channel sample; narrower samples sit zero-extended in the fields.
  localparam int I2S_MAX_DATA_W = 32;

  typedef struct packed {
    logic [I2S_MAX_DATA_W-1:0] left;
    logic [I2S_MAX_DATA_W-1:0] right;
  } i2s_stereo_t;

  function automatic int i2s_clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: synchronous FIFO holding packed {left, right} stereo samples.
// Push is ignored when full and pop when empty; DEPTH must be a power of two.
module i2s_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_param.sv
// i2s_tx_param: Philips-format I2S transmitter with stereo-sample FIFO.
// Define I2S_TX_UNDERRUN_HOLD_EN to repeat the last popped sample on underrun.
module i2s_tx_param
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 16,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_left,
  input  logic [DATA_W-1:0]           s_right,
  output logic                        bclk,
  output logic                        lrclk,
  output logic                        sdata,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DIV_W   = i2s_clog2w(BCLK_DIV);
  localparam int BIT_W   = i2s_clog2w(FRAME_W);

  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic [FRAME_W-1:0]  r_shift;
  logic                r_bclk;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_underrun;

  logic                w_full;
  logic                w_empty;
  logic                w_tick;
  logic                w_fall;
  logic                w_frame_start;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_rdata;
  i2s_stereo_t         w_head;
  i2s_stereo_t         w_frame_src;
  logic [FRAME_W-1:0]  w_image;

  // Slot image is MSB-first: sample bits, then zero padding up to SLOT_W.
  function automatic logic [FRAME_W-1:0] frame_image(input i2s_stereo_t s);
    return {SLOT_W'({{SLOT_W{1'b0}}, s.left}  << (SLOT_W - DATA_W)),
            SLOT_W'({{SLOT_W{1'b0}}, s.right} << (SLOT_W - DATA_W))};
  endfunction

  i2s_sample_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (s_valid),
    .i_pop   (w_pop),
    .i_wdata ({s_left, s_right}),
    .o_rdata (w_rdata),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_ready       = !w_full;
  assign w_tick        = enable && (r_div == DIV_W'(BCLK_DIV - 1));
  assign w_fall        = w_tick && r_bclk;
  assign w_frame_start = w_fall && (r_bit == '0);
  assign w_pop         = w_frame_start && !w_empty;

  always_comb begin
    w_head       = '0;
    w_head.left  = I2S_MAX_DATA_W'(w_rdata[2*DATA_W-1:DATA_W]);
    w_head.right = I2S_MAX_DATA_W'(w_rdata[DATA_W-1:0]);
  end

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  i2s_stereo_t r_hold;

  always_ff @(posedge clk) begin
    if (!rst_n)     r_hold <= '0;
    else if (w_pop) r_hold <= w_head;
  end

  assign w_frame_src = w_empty ? r_hold : w_head;
`else
  assign w_frame_src = w_empty ? '0 : w_head;
`endif

  assign w_image = frame_image(w_frame_src);

  // The frame-start falling edge still emits the previous frame's last bit
  // (the right LSB in Philips timing) before the new image is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= CH_RIGHT;
      r_sdata <= 1'b0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
      if (r_bclk) begin
        r_sdata <= r_shift[FRAME_W-1];
        r_lrclk <= (r_bit >= BIT_W'(SLOT_W)) ? CH_RIGHT : CH_LEFT;
        r_shift <= w_frame_start ? w_image : (r_shift << 1);
        r_bit   <= (r_bit == BIT_W'(FRAME_W - 1)) ? '0 : r_bit + 1'b1;
      end
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_underrun <= 1'b0;
    else        r_underrun <= w_frame_start && w_empty;
  end

  assign bclk     = r_bclk;
  assign lrclk    = r_lrclk;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx_param.sv
// tb_i2s_tx_param: directed and randomized checks of i2s_tx_param against a
// frame-level reference model (sample queue -> expected per-frame bit patterns).
module tb_i2s_tx_param;

  localparam int DW    = 16;
  localparam int SW    = 16;
  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int FW    = 2 * SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_left;
  logic [DW-1:0] s_right;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;
  logic [2:0]    fifo_level;

  int checks = 0;
  int errors = 0;

  logic [2*DW-1:0] m_q[$];
  logic [2*DW-1:0] m_hold;
  logic [1:0]      cap[$];
  int              ur_cnt = 0;
  bit              mon_on = 1'b0;
  int              cyc = 0;
  int              last_rise = -1;
  logic            p_bclk = 1'b0;
  logic            p_lr = 1'b1;
  logic            p_sd = 1'b0;
  logic            p_ur = 1'b0;

  i2s_tx_param #(
    .DATA_W     (DW),
    .SLOT_W     (SW),
    .BCLK_DIV   (BD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bclk"},     64'(bclk),     64'(1'b0));
    chk({tag, "_lrclk"},    64'(lrclk),    64'(1'b1));
    chk({tag, "_sdata"},    64'(sdata),    64'(1'b0));
    chk({tag, "_underrun"}, 64'(underrun), 64'(1'b0));
  endtask

  // Output monitor: samples just after each rising clk edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n && enable && mon_on) begin
      if (p_bclk && !bclk) cap.push_back({lrclk, sdata});
      else chk("change_off_fall", 64'({lrclk, sdata}), 64'({p_lr, p_sd}));
      if (!p_bclk && bclk) begin
        if (last_rise >= 0) chk("bclk_period", 64'(cyc - last_rise), 64'(2 * BD));
        last_rise = cyc;
      end
      if (underrun) begin
        ur_cnt++;
        chk("underrun_width", 64'(p_ur), 64'(1'b0));
      end
    end else begin
      last_rise = -1;
    end
    p_bclk = bclk;
    p_lr   = lrclk;
    p_sd   = sdata;
    p_ur   = underrun;
  end

  // Expected bit at falling-edge position p of a frame (Philips: 1-bit delay).
  function automatic logic exp_bit(input int p, input logic [DW-1:0] l,
                                   input logic [DW-1:0] r, input logic carry);
    if (p == 0) return carry;
    if (p <= DW) return l[DW - p];
    if (p > SW && p <= SW + DW) return r[SW + DW - p];
    return 1'b0;
  endfunction

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    chk("s_ready_before_push", 64'(s_ready), 64'(m_q.size() != DEPTH));
    @(negedge clk);
    s_valid = 1'b0;
    if (m_q.size() != DEPTH) m_q.push_back({l, r});
    chk("level_after_push", 64'(fifo_level), 64'(m_q.size()));
  endtask

  task automatic start_run();
    int n;
    cap.delete();
    ur_cnt = 0;
    mon_on = 1'b1;
    enable = 1'b1;
    n = 0;
    while (bclk !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_rise_delay", 64'(n), 64'(BD));
    while (lrclk !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("first_frame_delay", 64'(n), 64'(2 * BD));
  endtask

  task automatic finish_run(input int nf);
    int n;
    int exp_ur;
    logic carry;
    logic [2*DW-1:0] smp;
    logic [FW-1:0] exp_lr, exp_sd, got_lr, got_sd;
    logic [1:0] e;
    n = 0;
    while (cap.size() < FW * nf && n < 2 * BD * FW * (nf + 1)) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    mon_on = 1'b0;
    chk("capture_count", 64'(cap.size()), 64'(FW * nf));
    @(negedge clk);
    chk_idle("idle_after_run");
    carry  = 1'b0;
    exp_ur = 0;
    for (int k = 0; k < nf; k++) begin
      if (m_q.size() > 0) begin
        smp    = m_q.pop_front();
        m_hold = smp;
      end else begin
        exp_ur++;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        smp = m_hold;
`else
        smp = '0;
`endif
      end
      for (int p = 0; p < FW; p++) begin
        exp_lr[FW-1-p] = (p >= SW);
        exp_sd[FW-1-p] = exp_bit(p, smp[2*DW-1:DW], smp[DW-1:0], carry);
        e = (k * FW + p < cap.size()) ? cap[k * FW + p] : 2'bxx;
        got_lr[FW-1-p] = e[1];
        got_sd[FW-1-p] = e[0];
      end
      carry = (SW == DW) ? smp[0] : 1'b0;
      chk("frame_lrclk", 64'(got_lr), 64'(exp_lr));
      chk("frame_sdata", 64'(got_sd), 64'(exp_sd));
    end
    chk("underrun_count", 64'(ur_cnt), 64'(exp_ur));
    chk("level_after_run", 64'(fifo_level), 64'(m_q.size()));
  endtask

  initial begin
    logic [DW-1:0] word;
    logic [DW-1:0] l5, r5;
    int k;

    // Reset state
    rst_n   = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    m_hold  = '0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset_level", 64'(fifo_level), 64'(0));
    chk("reset_ready", 64'(s_ready), 64'(1'b1));
    rst_n = 1'b1;
    @(negedge clk);

    // Known sample, then a sample that later becomes the held value
    push(16'hA5A5, 16'h5A5F);
    push(16'h1234, 16'h1234);
    start_run();
    finish_run(2);
    word = '0;
    for (int p = 1; p <= DW; p++) word = {word[DW-2:0], cap[p][0]};
    chk("left_A5A5", 64'(word), 64'(16'hA5A5));
    word = '0;
    for (int p = SW + 1; p <= SW + DW; p++) word = {word[DW-2:0], cap[p][0]};
    chk("right_5A5F", 64'(word), 64'(16'h5A5F));

    // Empty FIFO: one underrun pulse per frame
    start_run();
    finish_run(2);

    // Fill while disabled, hold a fifth sample across the first pop
    for (int i = 0; i < DEPTH; i++) push(16'($urandom), 16'($urandom));
    chk("full_ready", 64'(s_ready), 64'(1'b0));
    chk("full_level", 64'(fifo_level), 64'(DEPTH));
    l5 = 16'($urandom);
    r5 = 16'($urandom);
    s_left  = l5;
    s_right = r5;
    s_valid = 1'b1;
    start_run();
    chk("pop_cycle_level", 64'(fifo_level), 64'(DEPTH - 1));
    chk("pop_cycle_ready", 64'(s_ready), 64'(1'b1));
    @(negedge clk);
    s_valid = 1'b0;
    chk("fifth_accepted", 64'(fifo_level), 64'(DEPTH));
    m_q.push_back({l5, r5});
    finish_run(5);

    // Disable mid-left-slot for 10 cycles, then resume with the next entry
    for (int i = 0; i < 3; i++) push(16'($urandom), 16'($urandom));
    start_run();
    for (int i = 0; i < 12; i++) @(negedge clk);
    enable = 1'b0;
    mon_on = 1'b0;
    m_hold = m_q.pop_front();
    @(negedge clk);
    chk_idle("disable");
    chk("disable_level", 64'(fifo_level), 64'(m_q.size()));
    for (int i = 0; i < 9; i++) @(negedge clk);
    chk("disabled_level_kept", 64'(fifo_level), 64'(m_q.size()));
    start_run();
    finish_run(2);

    // Reset mid-frame with three entries left
    for (int i = 0; i < DEPTH; i++) push(16'($urandom), 16'($urandom));
    start_run();
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("pre_reset_level", 64'(fifo_level), 64'(DEPTH - 1));
    mon_on = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk_idle("midframe_reset");
    chk("midframe_reset_level", 64'(fifo_level), 64'(0));
    chk("midframe_reset_ready", 64'(s_ready), 64'(1'b1));
    enable = 1'b0;
    rst_n  = 1'b1;
    m_q.delete();
    m_hold = '0;
    @(negedge clk);
    start_run();
    finish_run(1);

    // Randomized fills, each run ending with one underrun frame
    for (int it = 0; it < 3; it++) begin
      k = $urandom_range(0, DEPTH);
      for (int i = 0; i < k; i++) push(16'($urandom), 16'($urandom));
      start_run();
      finish_run(k + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
